// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and constants for the wide serial adder (package wide_add_pkg).
package wide_add_pkg;
  localparam int CHUNK_W   = 16;
  localparam int WORDS_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/wide_add_sequencer_if.sv
// Operand/result bundle for wide_add_sequencer; sub_i exists only when WIDE_ADD_SUB_EN is defined.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready are both high.
interface wide_add_sequencer_if #(parameter int WORDS = 4);
  import wide_add_pkg::*;

  logic                       in_valid_i;
  logic                       in_ready_o;
  logic [CHUNK_W*WORDS-1:0]   a_i;
  logic [CHUNK_W*WORDS-1:0]   b_i;
  logic                       carry_i;
`ifdef WIDE_ADD_SUB_EN
  logic                       sub_i;
`endif
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [CHUNK_W*WORDS:0]     sum_o;

  modport master (
    output
`ifdef WIDE_ADD_SUB_EN
           sub_i,
`endif
           in_valid_i, a_i, b_i, carry_i, out_ready_i,
    input  in_ready_o, out_valid_o, sum_o
  );

  modport slave (
    input
`ifdef WIDE_ADD_SUB_EN
           sub_i,
`endif
           in_valid_i, a_i, b_i, carry_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o
  );
endinterface

// File: rtl/carry_lookahead_adder_16_bit.sv
// 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate lookahead.
module carry_lookahead_adder_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [16:0] sum
);
  logic [15:0] g, p;
  logic [16:0] c;
  logic [3:0]  gg, pg;
  logic [4:0]  cg;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    pg = '0;
    cg = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
    // Group carries resolve in parallel; only the in-group carries use the short chain.
    cg[0] = carry_in;
    cg[1] = gg[0] | (pg[0] & carry_in);
    cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & carry_in);
    cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & carry_in);
    cg[4] = gg[3] | (pg[3] & cg[3]);
    for (int k = 0; k < 4; k++) begin
      c[4*k] = cg[k];
      for (int i = 0; i < 3; i++) begin
        c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
      end
    end
    c[16] = cg[4];
    sum   = {c[16], p ^ c[15:0]};
  end
endmodule

// File: rtl/wide_add_sequencer.sv
// Serial multi-word adder feeding one 16-bit chunk per cycle (LSW first) through a CLA.
// Optional subtract mode is enabled with the WIDE_ADD_SUB_EN macro.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wide_add_sequencer_if.slave   bus,
  output state_t                dbg_state
);
  localparam int CNT_W = $clog2((WORDS < 2) ? 2 : WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);
  localparam int DW = CHUNK_W * WORDS;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    a_q, b_q;
  logic             c_q;
  logic [DW:0]      sum_q;
  logic [15:0]      cla_a, cla_b;
  logic [16:0]      cla_sum;
  logic             accept;
`ifdef WIDE_ADD_SUB_EN
  logic             sub_q;
`endif

  assign accept = bus.in_valid_i && bus.in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ADD;
      ADD:     if (cnt == LAST) state_next = DONE;
      DONE:    if (bus.out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready_o  = (state == IDLE) && !rst_i;
    bus.out_valid_o = (state == DONE);
    dbg_state       = state;
  end

  // Subtraction is A + ~B + 1, so only the B chunk and the initial carry differ.
  always_comb begin
    cla_a = a_q[cnt*CHUNK_W +: CHUNK_W];
    cla_b = b_q[cnt*CHUNK_W +: CHUNK_W];
`ifdef WIDE_ADD_SUB_EN
    cla_b = cla_b ^ {CHUNK_W{sub_q}};
`endif
  end

  carry_lookahead_adder_16_bit u_cla (
    .a        (cla_a),
    .b        (cla_b),
    .carry_in (c_q),
    .sum      (cla_sum)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      cnt   <= '0;
      sum_q <= '0;
`ifdef WIDE_ADD_SUB_EN
      sub_q <= 1'b0;
`endif
    end else begin
      if (state == IDLE && accept) begin
        a_q <= bus.a_i;
        b_q <= bus.b_i;
        cnt <= '0;
`ifdef WIDE_ADD_SUB_EN
        sub_q <= bus.sub_i;
        c_q   <= bus.sub_i ? 1'b1 : bus.carry_i;
`else
        c_q   <= bus.carry_i;
`endif
      end else if (state == ADD) begin
        sum_q[cnt*CHUNK_W +: CHUNK_W] <= cla_sum[15:0];
        c_q <= cla_sum[16];
        cnt <= cnt + 1'b1;
        if (cnt == LAST) sum_q[DW] <= cla_sum[16];
      end
    end
  end

  assign bus.sum_o = sum_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed scoreboard bench for wide_add_sequencer (WORDS=4 and WORDS=1 instances).
module tb_wide_add_sequencer;
  import wide_add_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  wide_add_sequencer_if #(.WORDS(4)) bus4();
  wide_add_sequencer_if #(.WORDS(1)) bus1();
  state_t st4, st1;

  wide_add_sequencer #(.WORDS(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4), .dbg_state(st4));
  wide_add_sequencer #(.WORDS(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1), .dbg_state(st1));

  logic [64:0] exp_q4[$];
  logic [16:0] exp_q1[$];

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: timeout or unexpected event", name);
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (!rst && bus4.out_valid_o && bus4.out_ready_i) begin
      if (exp_q4.size() == 0) fail_now("w4_unexpected_result");
      else check("w4_result", bus4.sum_o, exp_q4.pop_front());
    end
    if (!rst && bus1.out_valid_o && bus1.out_ready_i) begin
      if (exp_q1.size() == 0) fail_now("w1_unexpected_result");
      else check("w1_result", {48'd0, bus1.sum_o}, {48'd0, exp_q1.pop_front()});
    end
  end

  // driver tasks
  task automatic send4(input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic sub, input logic [64:0] exp, input bit push);
    int guard = 0;
    while (!bus4.in_ready_o && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 100) begin
      fail_now("w4_in_ready_timeout");
      return;
    end
    bus4.in_valid_i = 1'b1;
    bus4.a_i        = a;
    bus4.b_i        = b;
    bus4.carry_i    = cin;
`ifdef WIDE_ADD_SUB_EN
    bus4.sub_i      = sub;
`else
    if (sub) fail_now("sub_requested_without_feature");
`endif
    if (push) exp_q4.push_back(exp);
    @(posedge clk); #1;
    bus4.in_valid_i = 1'b0;
  endtask

  task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [16:0] exp);
    int guard = 0;
    while (!bus1.in_ready_o && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 100) begin
      fail_now("w1_in_ready_timeout");
      return;
    end
    bus1.in_valid_i = 1'b1;
    bus1.a_i        = a;
    bus1.b_i        = b;
    bus1.carry_i    = cin;
    exp_q1.push_back(exp);
    @(posedge clk); #1;
    bus1.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q4.size() != 0 || exp_q1.size() != 0) && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 200) fail_now("drain_timeout");
  endtask

  initial begin
    int lat;
    int guard;
    bus4.in_valid_i = 1'b0; bus4.a_i = '0; bus4.b_i = '0; bus4.carry_i = 1'b0; bus4.out_ready_i = 1'b1;
    bus1.in_valid_i = 1'b0; bus1.a_i = '0; bus1.b_i = '0; bus1.carry_i = 1'b0; bus1.out_ready_i = 1'b1;
`ifdef WIDE_ADD_SUB_EN
    bus4.sub_i = 1'b0;
    bus1.sub_i = 1'b0;
`endif

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_low", 65'(bus4.in_ready_o), 65'd0);
    check("rst_out_valid", 65'(bus4.out_valid_o), 65'd0);
    check("rst_sum", bus4.sum_o, 65'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 65'(bus4.in_ready_o), 65'd1);

    // carry ripples through all four chunks; check latency to out_valid
    send4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 65'h1_0000_0000_0000_0000, 1'b1);
    check("busy_in_ready", 65'(bus4.in_ready_o), 65'd0);
    lat = 0;
    while (!bus4.out_valid_o && lat < 20) begin
      @(negedge clk); lat++;
    end
    check("latency_negedges", 65'(lat), 65'd5);

    send4(64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_0F0F, 1'b1, 1'b0, 65'h0_0000_0000_0001_0000, 1'b1);
    send4(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
          {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1);
    send1(16'hFFFF, 16'hFFFF, 1'b0, 17'h1_FFFE);
    send1(16'h1234, 16'h0001, 1'b1, 17'h0_1236);
    drain();

    // backpressure: result held, new operands refused
    bus4.out_ready_i = 1'b0;
    send4(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
          65'h0_1234_5678_9ABC_DF00, 1'b1);
    guard = 0;
    while (!bus4.out_valid_o && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 20) fail_now("bp_out_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      bus4.in_valid_i = 1'b1;
      bus4.a_i = 64'hFFFF_FFFF_FFFF_FFFF;
      bus4.b_i = 64'h5555_5555_5555_5555;
      @(negedge clk);
      check("bp_out_valid", 65'(bus4.out_valid_o), 65'd1);
      check("bp_in_ready", 65'(bus4.in_ready_o), 65'd0);
      check("bp_sum_held", bus4.sum_o, 65'h0_1234_5678_9ABC_DF00);
      @(posedge clk); #1;
    end
    bus4.in_valid_i  = 1'b0;
    bus4.out_ready_i = 1'b1;
    drain();
    repeat (10) @(posedge clk);
    #1;
    check("bp_no_phantom", 65'(bus4.out_valid_o), 65'd0);

    // reset mid-ADD (cnt==2) discards the partial result
    send4(64'h1111_2222_3333_4444, 64'h1, 1'b0, 1'b0, 65'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_state_add", 65'(st4), 65'(ADD));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_out_valid", 65'(bus4.out_valid_o), 65'd0);
    check("post_rst_sum", bus4.sum_o, 65'd0);
    check("post_rst_in_ready", 65'(bus4.in_ready_o), 65'd1);
    check("post_rst_state_w1", 65'(st1), 65'(IDLE));
    send4(64'd3, 64'd4, 1'b0, 1'b0, 65'h7, 1'b1);

`ifdef WIDE_ADD_SUB_EN
    send4(64'd5, 64'd7, 1'b1, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, 1'b1);
    send4(64'd7, 64'd5, 1'b0, 1'b1, {1'b1, 64'h2}, 1'b1);
    send4(64'd9, 64'd9, 1'b0, 1'b0, 65'h12, 1'b1);
`endif

    drain();
    check("w4_queue_empty", 65'(exp_q4.size()), 65'd0);
    check("w1_queue_empty", 65'(exp_q1.size()), 65'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-word serial adder controller that sits directly upstream of the 16-bit carry-lookahead adder. It takes a WORDS×16-bit operand pair over a valid/ready handshake and feeds one 16-bit chunk per cycle, LSW first, through `carry_lookahead_adder_16_bit`. It chains the carry between chunks and returns a (16·WORDS+1)-bit result over a second valid/ready handshake. This gives the datapath wide additions without widening the CLA.

## Interface
- `WORDS`, 4, number of 16-bit chunks per operand; legal range 1..8.
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `in_valid_i`  in  1  operand pair and carry-in valid.
- `in_ready_o`  out  1  block can accept an operation.
- `a_i`  in  16·WORDS  operand A.
- `b_i`  in  16·WORDS  operand B.
- `carry_i`  in  1  carry-in to chunk 0.
- `sub_i`  in  1  subtract request; present only with `WIDE_ADD_SUB_EN`.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  downstream accepts the result.
- `sum_o`  out  16·WORDS+1  result; MSB is the final carry-out.

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - `in_ready_o`=1.
  - On `in_valid_i`&&`in_ready_o`, latch `a_i`, `b_i` and the carry into internal registers.
  - Clear the chunk counter `cnt` to 0, then go to ADD.
- ADD, one chunk per cycle:
  - CLA inputs are A[16·cnt+:16], B[16·cnt+:16] and the running carry c.
  - At each edge, write CLA sum[15:0] into result slice cnt, set c to CLA sum[16], and increment `cnt`.
  - After processing chunk WORDS−1, write the final c into `sum_o[16·WORDS]` and go to DONE.
- DONE:
  - `out_valid_o`=1; `sum_o` is held stable.
  - On `out_valid_o`&&`out_ready_i`, go to IDLE.
- `sum_o` keeps its last value after the transfer and is overwritten only as chunks complete in the next operation.
- `in_ready_o`=0 in ADD and DONE. `in_valid_i` is ignored there; no queueing.
- Arithmetic: `sum_o` = A + B + carry, computed modulo 2^(16·WORDS+1), with no truncation.
- WORDS=1: the block takes a single ADD cycle and its result matches a direct CLA call.
- `cnt` width is clog2(max(WORDS,2)).

## Timing
- Reset values: state IDLE, `out_valid_o`=0, `sum_o`=0, `cnt`=0, c=0.
- `in_ready_o` is combinational and equals (state==IDLE)&&!`rst_i`.
- Reset asserted in any state, including mid-ADD or DONE, aborts the operation and discards the partial result. State, counter, carry and `sum_o` all clear at that edge.
- Latency: acceptance at edge T0, chunks processed at edges T1..TWORDS. `out_valid_o` rises after edge TWORDS.
- Result transfer at edge Tx returns the FSM to IDLE, so `in_ready_o`=1 in the cycle after Tx.
- Minimum spacing between accepts is WORDS+2 cycles.
- Backpressure: while `out_ready_i`=0 in DONE, `out_valid_o` and `sum_o` must not change.
- All state changes happen on `clk_i` rising edges. The only combinational path is the CLA.

## Configuration
- `WIDE_ADD_SUB_EN` defined:
  - The `sub_i` port exists and is latched with the operands.
  - When `sub_i`=1, each B chunk is inverted before the CLA and the initial carry is forced to 1; `carry_i` is ignored.
  - `sum_o[16·WORDS]` is the no-borrow flag (1 means A≥B).
- `WIDE_ADD_SUB_EN` undefined: the `sub_i` port and inversion logic are absent, and the block is add-only.

## Structure
- Package `wide_add_pkg` holds:
  - `CHUNK_W`=16.
  - A state enum typedef: IDLE, ADD, DONE.
  - `WORDS_MAX`=8.
- Sub-module: one instance of the existing `carry_lookahead_adder_16_bit`, used unmodified.

## Test plan
All scenarios use WORDS=4 unless noted.
- A=64'hFFFF_FFFF_FFFF_FFFF, B=1, carry 0 -> `sum_o`=65'h1_0000_0000_0000_0000. `out_valid_o` rises after the 4th edge following accept.
- A=64'h0000_0000_0000_F0F0, B=64'h0000_0000_0000_0F0F, carry 1 -> `sum_o`=65'h0_0000_0000_0001_0000, which checks carry chaining into chunk 1.
- A=B=all ones, carry 1 -> `sum_o`={1'b1, 64'hFFFF_FFFF_FFFF_FFFF}. Repeat with WORDS=1 and A=B=16'hFFFF, carry 0 -> 17'h1_FFFE.
- Backpressure: hold `out_ready_i`=0 for 5 cycles while pulsing `in_valid_i` -> `sum_o` and `out_valid_o` stay stable, `in_ready_o`=0, and the new operand is not accepted.
- Assert `rst_i` when `cnt`=2 -> next cycle `out_valid_o`=0, `sum_o`=0, `in_ready_o`=1. A following add of 3+4 returns 65'h7.
- With `WIDE_ADD_SUB_EN`:
  - A=5, B=7, `sub_i`=1 -> `sum_o`={1'b0, 64'hFFFF_FFFF_FFFF_FFFE}.
  - A=7, B=5 -> `sum_o`={1'b1, 64'h2}.
